// File: rtl/pito_imem_loader.sv
// pito_imem_loader: frames a byte stream as [N][N words][XOR checksum] and
// writes the payload into the core's instruction memory. The core stays in
// program mode until the image is loaded and the checksum matches.
module pito_imem_loader #(
  parameter int unsigned IMEM_DEPTH  = 8192,
  parameter int unsigned IMEM_ADDR_W = 32
) (
  input  logic                   rv32_io_clk,
  input  logic                   rv32_io_rst,
  input  logic                   ldr_start,
  input  logic                   ldr_byte_valid,
  input  logic [7:0]             ldr_byte_data,
  output logic                   ldr_byte_ready,
  output logic                   imem_w_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_data,
  output logic                   rv32_io_program,
  output logic                   ldr_busy,
  output logic                   ldr_done,
  output logic [1:0]             ldr_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_idx;   // position of the next byte inside the word
  logic [23:0] asm_q;      // first three bytes of the word being assembled
  logic [31:0] word_n;     // payload length latched from the header
  logic [31:0] word_idx;   // index of the next payload word
  logic [31:0] csum;       // running XOR of payload words

  logic        start_ok;
  logic        xfer;
  logic        word_done;
  logic [31:0] word;

  // A start is honoured only when no load is in flight.
  assign start_ok  = ldr_start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign ldr_byte_ready = (state inside {S_HDR, S_LOAD, S_CSUM});
  assign xfer      = ldr_byte_valid && ldr_byte_ready;
  assign word_done = xfer && (byte_idx == 2'd3);
  // The 4th byte completes the word directly from the input, so the write
  // strobe can be registered in the same cycle the byte arrives.
  assign word      = {ldr_byte_data, asm_q};

  assign ldr_busy        = ldr_byte_ready;
  // ERR keeps the core parked so a partial image never runs.
  assign rv32_io_program = ldr_busy || (state == S_ERR);
  assign ldr_done        = (state == S_DONE);

  // State register.
  always_ff @(posedge rv32_io_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rv32_io_rst) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic driven by start pulses and completed words.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred for state_nxt.
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_nxt = S_HDR;
      S_HDR: begin
        if (word_done) begin
          if (word > 32'(IMEM_DEPTH)) state_nxt = S_ERR;
          else if (word == 32'd0)     state_nxt = S_CSUM;
          else                        state_nxt = S_LOAD;
        end
      end
      S_LOAD: if (word_done && (word_idx == word_n - 32'd1)) state_nxt = S_CSUM;
      S_CSUM: if (word_done) state_nxt = (word == csum) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte assembly, header latch, imem write port, checksum and error code.
  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      byte_idx  <= '0;
      asm_q     <= '0;
      word_n    <= '0;
      word_idx  <= '0;
      csum      <= '0;
      imem_w_en <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      ldr_err   <= 2'd0;
    end else begin
      imem_w_en <= 1'b0;
      if (start_ok) begin
        byte_idx <= '0;
        asm_q    <= '0;
        word_n   <= '0;
        word_idx <= '0;
        csum     <= '0;
        ldr_err  <= 2'd0;
      end else if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= ldr_byte_data;
          2'd1:    asm_q[15:8]  <= ldr_byte_data;
          2'd2:    asm_q[23:16] <= ldr_byte_data;
          default: asm_q        <= asm_q;
        endcase
        if (word_done) begin
          unique case (state)
            S_HDR: begin
              word_n <= word;
              if (word > 32'(IMEM_DEPTH)) ldr_err <= 2'd1;
            end
            S_LOAD: begin
              imem_w_en <= 1'b1;
              imem_addr <= IMEM_ADDR_W'(word_idx);
              imem_data <= word;
              csum      <= csum ^ word;
              word_idx  <= word_idx + 32'd1;
            end
            S_CSUM: if (word != csum) ldr_err <= 2'd2;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pito_imem_loader.sv
// tb_pito_imem_loader: drives framed images byte by byte, pushes expected
// imem writes into a scoreboard and pops them as the DUT strobes imem_w_en.
module tb_pito_imem_loader;

  localparam int unsigned DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldr_start;
  logic        ldr_byte_valid;
  logic [7:0]  ldr_byte_data;
  logic        ldr_byte_ready;
  logic        imem_w_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        rv32_io_program;
  logic        ldr_busy;
  logic        ldr_done;
  logic [1:0]  ldr_err;

  pito_imem_loader #(.IMEM_DEPTH(DEPTH), .IMEM_ADDR_W(32)) dut (
    .rv32_io_clk     (clk),
    .rv32_io_rst     (rst),
    .ldr_start       (ldr_start),
    .ldr_byte_valid  (ldr_byte_valid),
    .ldr_byte_data   (ldr_byte_data),
    .ldr_byte_ready  (ldr_byte_ready),
    .imem_w_en       (imem_w_en),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .rv32_io_program (rv32_io_program),
    .ldr_busy        (ldr_busy),
    .ldr_done        (ldr_done),
    .ldr_err         (ldr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_e;
  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;
  logic        prev_wen = 1'b0;
  logic [31:0] img [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr,data} entry.
  always @(negedge clk) begin
    if (imem_w_en) begin
      check("wen_single_cycle", 32'(prev_wen), 32'd0);
      wr_count++;
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("imem_addr", imem_addr, exp_e.addr);
        check("imem_data", imem_data, exp_e.data);
      end
    end
    prev_wen = imem_w_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ldr_start = 1'b1;
    tick();
    ldr_start = 1'b0;
  endtask

  // One byte, optionally preceded by idle cycles carrying garbage data.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        ldr_byte_valid = 1'b0;
        ldr_byte_data  = 8'($urandom);
        tick();
      end
    end
    ldr_byte_valid = 1'b1;
    ldr_byte_data  = b;
    tick();
    ldr_byte_valid = 1'b0;
  endtask

  // Little-endian word; one cycle after the last byte the write strobe must
  // be present exactly when this is a payload word.
  task automatic send_word(input logic [31:0] w, input bit is_payload, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    check(is_payload ? "write_latency" : "no_write", 32'(imem_w_en), 32'(is_payload));
  endtask

  // Header, nw payload words (from img when use_img, else random), checksum.
  // The checksum is the model XOR, optionally corrupted.
  task automatic send_image(input logic [31:0] n, input int nw, input bit use_img,
                            input bit gaps, input bit bad_csum);
    logic [31:0] w;
    logic [31:0] cs;
    cs = 32'd0;
    send_word(n, 1'b0, gaps);
    for (int i = 0; i < nw; i++) begin
      w = use_img ? img[i] : $urandom;
      cs ^= w;
      exp_q.push_back('{addr: 32'(i), data: w});
      send_word(w, 1'b1, gaps);
    end
    send_word(bad_csum ? (cs ^ 32'd1) : cs, 1'b0, gaps);
  endtask

  task automatic check_done(input string tag, input int wr_before, input int nwr);
    check({tag, "_done"},    32'(ldr_done), 32'd1);
    check({tag, "_program"}, 32'(rv32_io_program), 32'd0);
    check({tag, "_err"},     32'(ldr_err), 32'd0);
    check({tag, "_busy"},    32'(ldr_busy), 32'd0);
    check({tag, "_writes"},  32'(wr_count - wr_before), 32'(nwr));
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"},   32'(ldr_byte_ready), 32'd0);
    check({tag, "_wen"},     32'(imem_w_en), 32'd0);
    check({tag, "_addr"},    imem_addr, 32'd0);
    check({tag, "_data"},    imem_data, 32'd0);
    check({tag, "_program"}, 32'(rv32_io_program), 32'd0);
    check({tag, "_busy"},    32'(ldr_busy), 32'd0);
    check({tag, "_done"},    32'(ldr_done), 32'd0);
    check({tag, "_err"},     32'(ldr_err), 32'd0);
  endtask

  int wb;

  initial begin
    rst = 1'b1; ldr_start = 1'b0; ldr_byte_valid = 1'b0; ldr_byte_data = 8'h00;
    img[0] = 32'h0000_0013; img[1] = 32'h0010_0093; img[2] = 32'h0020_8113;
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Case 1: three-word image, checksum 0x00308193.
    pulse_start();
    check("c1_program_rise", 32'(rv32_io_program), 32'd1);
    check("c1_ready_hdr", 32'(ldr_byte_ready), 32'd1);
    wb = wr_count;
    send_image(32'd3, 3, 1'b1, 1'b0, 1'b0);
    check_done("c1", wb, 3);

    // Case 2a: bytes in DONE are refused; start with a same-cycle byte drops it.
    ldr_byte_valid = 1'b1; ldr_byte_data = 8'hFF;
    #1 check("c2_ready_done", 32'(ldr_byte_ready), 32'd0);
    ldr_start = 1'b1;
    tick();
    ldr_start = 1'b0; ldr_byte_valid = 1'b0;
    check("c2_done_cleared", 32'(ldr_done), 32'd0);
    check("c2_busy", 32'(ldr_busy), 32'd1);
    wb = wr_count;
    send_image(32'd0, 0, 1'b1, 1'b0, 1'b0);
    check_done("c2a", wb, 0);

    // Case 2b: N=0 with wrong checksum.
    pulse_start();
    send_image(32'd0, 0, 1'b1, 1'b0, 1'b1);
    check("c2b_err", 32'(ldr_err), 32'd2);
    check("c2b_program", 32'(rv32_io_program), 32'd1);
    check("c2b_done", 32'(ldr_done), 32'd0);

    // Case 3: oversize header errors immediately; later bytes are ignored.
    pulse_start();
    check("c3_err_cleared", 32'(ldr_err), 32'd0);
    wb = wr_count;
    send_word(32'(DEPTH + 1), 1'b0, 1'b0);
    check("c3_err", 32'(ldr_err), 32'd1);
    check("c3_program", 32'(rv32_io_program), 32'd1);
    check("c3_busy", 32'(ldr_busy), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0);
    check("c3_err_held", 32'(ldr_err), 32'd1);
    check("c3_writes", 32'(wr_count - wb), 32'd0);

    // Case 4: case-1 image with random valid gaps.
    pulse_start();
    wb = wr_count;
    send_image(32'd3, 3, 1'b1, 1'b1, 1'b0);
    check_done("c4", wb, 3);

    // Case 5: reset after two of three words, then a clean reload.
    pulse_start();
    send_word(32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: 32'(i), data: img[i]});
      send_word(img[i], 1'b1, 1'b0);
    end
    rst = 1'b1;
    tick();
    check_idle_zero("c5_rst");
    rst = 1'b0;
    tick();
    pulse_start();
    wb = wr_count;
    send_image(32'd3, 3, 1'b1, 1'b0, 1'b0);
    check_done("c5", wb, 3);

    // Case 6: start during LOAD is ignored; start in DONE re-enters HDR.
    pulse_start();
    wb = wr_count;
    send_word(32'd3, 1'b0, 1'b0);
    exp_q.push_back('{addr: 32'd0, data: img[0]});
    send_word(img[0], 1'b1, 1'b0);
    pulse_start();
    check("c6_busy_kept", 32'(ldr_busy), 32'd1);
    for (int i = 1; i < 3; i++) begin
      exp_q.push_back('{addr: 32'(i), data: img[i]});
      send_word(img[i], 1'b1, 1'b0);
    end
    send_word(32'h0030_8193, 1'b0, 1'b0);
    check_done("c6", wb, 3);
    pulse_start();
    check("c6_done_cleared", 32'(ldr_done), 32'd0);
    check("c6_hdr_busy", 32'(ldr_busy), 32'd1);

    // Boundary: N == DEPTH is legal, last write lands at DEPTH-1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    wb = wr_count;
    send_image(32'(DEPTH), DEPTH, 1'b0, 1'b0, 1'b0);
    check("max_last_addr", imem_addr, 32'(DEPTH - 1));
    check_done("max", wb, DEPTH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
